mac_operand_sequencer: RTL and testbench
========================================

Name: mac_operand_sequencer

Overview:
Initiator side of the MAC unit interface: owns the clk/reset/enable/x/w/acc handshake that a bench drives by hand today.
- Holds two small operand buffers (activations x, weights w), loaded through a simple write port.
- On start, clears the MAC, streams len operand pairs into it on consecutive cycles, waits for the final accumulate, captures acc, and pulses done.
- Sits between the control/loader logic and one mac_unit instance.

Parameters:
DATA_W, 8, operand width (x, w)
ACC_W, 16, MAC accumulator width; must match the mac_unit acc width
DEPTH, 16, entries per operand buffer
ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  operand buffer write strobe
wr_sel  input  1  0 = x buffer, 1 = w buffer
wr_addr  input  ADDR_W  buffer write index
wr_data  input  DATA_W  buffer write data
start  input  1  begin a dot-product run; sampled only in IDLE
len  input  ADDR_W+1  number of operand pairs to stream; sampled with start
busy  output  1  run in progress
done  output  1  one-cycle pulse; result valid
result  output  ACC_W  captured MAC sum, held until next done
ovf  output  1  overflow flag, valid with done (see Optional Feature)
mac_reset  output  1  to mac_unit reset
mac_enable  output  1  to mac_unit enable
mac_x  output  DATA_W  to mac_unit x
mac_w  output  DATA_W  to mac_unit w
mac_acc  input  ACC_W  from mac_unit acc

Behaviour:
- One clock domain; reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - busy=0, done=0, result=0, ovf=0
  - mac_reset=0, mac_enable=0, mac_x=0, mac_w=0
  - both buffers cleared to 0
  - FSM in IDLE
- MAC contract: on each rising edge, mac_reset=1 clears acc; otherwise mac_enable=1 does acc <= acc + x*w, wrapping modulo 2^ACC_W.
- FSM states: IDLE, CLEAR, STREAM, WAIT, CAPTURE.
  - IDLE: start=1 latches eff_len = min(len, DEPTH) and goes to CLEAR. Call that edge E0.
  - CLEAR (cycle 1 after E0): mac_reset=1, mac_enable=0. If eff_len=0, go to WAIT; else go to STREAM with index i=0.
  - STREAM (cycles 2..eff_len+1): mac_enable=1, mac_x=xbuf[i], mac_w=wbuf[i], i increments each cycle. Leave to WAIT after the cycle with i=eff_len-1.
  - WAIT (one cycle): mac_enable=0, mac_x=0, mac_w=0. mac_acc now holds the full sum. Go to CAPTURE.
  - CAPTURE: the edge ending WAIT loads result<=mac_acc and sets done=1 for exactly one cycle. FSM returns to IDLE.
- Timing:
  - busy=1 from cycle 1 through the WAIT cycle.
  - busy=0 in the cycle where done=1.
  - Latency from the start-sampling edge to the done cycle is eff_len+3 cycles.
- start held high re-triggers on the first IDLE cycle after done.
- start while busy: ignored, no queuing.
- wr_en while busy: ignored, so buffers stay stable during a run.
- wr_en in IDLE: write lands on that edge. Write and start on the same edge: the write takes effect and the run uses the new value.
- len=0: CLEAR then WAIT, result=0, done at E0+3.
- len>DEPTH: clamped to DEPTH.
- reset mid-run: the FSM returns to IDLE on that edge, mac_enable=0, no done pulse, result cleared to 0.
- result holds its value until the next CAPTURE or reset.

Optional Feature:
Macro MAC_SEQ_OVF_DETECT_EN.
- Defined:
  - Sequencer keeps a shadow sum of width ACC_W+ADDR_W+1, cleared in CLEAR, accumulating mac_x*mac_w in lockstep with the MAC.
  - In CAPTURE, ovf <= (shadow sum >= 2^ACC_W). ovf is held with result and cleared by reset.
- Not defined:
  - ovf is tied to 0.
  - No shadow logic is present.
  - The port still exists.

Test Plan:
1. Basic run: write x[0..2]={2,4,6}, w[0..2]={3,5,7}, start with len=3 → mac_enable high exactly 3 cycles, done at E0+6, result=68, ovf=0.
2. len=0: start → no mac_enable cycles, done at E0+3, result=0.
3. Clamp: all x=1, w=1, len=20 (DEPTH=16) → 16 enable cycles, result=16.
4. Overflow: x[0..1]=255, w[0..1]=255, len=2 → result=64514. ovf=1 with the macro defined, 0 without.
5. Busy protection: during a len=3 run, pulse start and write x[0]=99 → no second run, result=68. A subsequent run still reads x[0]=2.
6. Reset mid-STREAM: assert reset on the second STREAM cycle → the next cycle has busy=0, mac_enable=0, result=0, and no done pulse. A fresh start then completes with the correct result.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: initiator for one mac_unit.
// Holds x/w operand buffers, streams len operand pairs into the MAC after
// clearing it, captures the accumulator and pulses done.
// Optional feature macro: MAC_SEQ_OVF_DETECT_EN (shadow-sum overflow flag).
// When the macro is undefined, ovf is tied to 0 and no shadow logic exists.
module mac_operand_sequencer #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output logic              ovf,
   output logic              mac_reset,
   output logic              mac_enable,
   output logic [DATA_W-1:0] mac_x,
   output logic [DATA_W-1:0] mac_w,
   input  logic [ACC_W-1:0]  mac_acc
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CLEAR   = 3'd1;
   localparam logic [2:0] STREAM  = 3'd2;
   localparam logic [2:0] WAIT    = 3'd3;
   localparam logic [2:0] CAPTURE = 3'd4;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [2:0]        state;
   logic [ADDR_W:0]   eff_len;   // pairs to stream in this run
   logic [ADDR_W:0]   cnt;       // pairs already issued to the MAC
   logic [ADDR_W:0]   len_clamped;
   logic              wr_ok;
   logic [DATA_W-1:0] xbuf [DEPTH];
   logic [DATA_W-1:0] wbuf [DEPTH];

   // Clamp the requested length to the buffer depth; gate writes outside a run.
   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
      wr_ok       = (state == IDLE) || (state == CAPTURE);
   end

   // Operand buffers: written through the write port only while no run is active.
   // NOTE: the buffers are small and must read as 0 after reset, so they are
   // cleared explicitly; large RAMs would normally be left unreset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            xbuf[i] <= '0;
            wbuf[i] <= '0;
         end
      end else if (wr_en && wr_ok) begin
         if (wr_sel) wbuf[wr_addr] <= wr_data;
         else        xbuf[wr_addr] <= wr_data;
      end
   end

   // Run FSM; every MAC-facing output is registered as the value for the next cycle.
   // NOTE: sequential state uses non-blocking assignments so that all registers
   // update together from the values seen before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         eff_len    <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         mac_reset  <= 1'b0;
         mac_enable <= 1'b0;
         mac_x      <= '0;
         mac_w      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  eff_len   <= len_clamped;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  mac_reset <= 1'b1;
                  state     <= CLEAR;
               end
            end
            CLEAR: begin
               mac_reset <= 1'b0;
               if (eff_len == '0) begin
                  state <= WAIT;
               end else begin
                  mac_enable <= 1'b1;
                  mac_x      <= xbuf[0];
                  mac_w      <= wbuf[0];
                  cnt        <= (ADDR_W+1)'(1);
                  state      <= STREAM;
               end
            end
            STREAM: begin
               if (cnt == eff_len) begin
                  mac_enable <= 1'b0;
                  mac_x      <= '0;
                  mac_w      <= '0;
                  state      <= WAIT;
               end else begin
                  mac_x <= xbuf[cnt[ADDR_W-1:0]];
                  mac_w <= wbuf[cnt[ADDR_W-1:0]];
                  cnt   <= cnt + 1'b1;
               end
            end
            WAIT: begin
               // The last accumulate landed on the previous edge; acc is final.
               result <= mac_acc;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               state <= IDLE;
            end
            default: begin
               busy       <= 1'b0;
               mac_reset  <= 1'b0;
               mac_enable <= 1'b0;
               mac_x      <= '0;
               mac_w      <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

`ifdef MAC_SEQ_OVF_DETECT_EN
   localparam int SHADOW_W = ACC_W + ADDR_W + 1;

   logic [SHADOW_W-1:0] shadow;

   // Wide shadow of the MAC sum, updated on exactly the edges the MAC updates.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= '0;
         ovf    <= 1'b0;
      end else begin
         if (mac_reset) begin
            shadow <= '0;
         end else if (mac_enable) begin
            shadow <= shadow + (SHADOW_W'(mac_x) * SHADOW_W'(mac_w));
         end
         if (state == WAIT) begin
            ovf <= |shadow[SHADOW_W-1:ACC_W];
         end
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer with a behavioural mac_unit.
// Expected results are computed from a bench-side copy of the operand buffers,
// queued at start and compared when done pulses.
module tb_mac_operand_sequencer;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   typedef struct {
      logic [ACC_W-1:0] result;
      logic             ovf;
      int               lat;
      int               nen;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic              wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              done;
   logic [ACC_W-1:0]  result;
   logic              ovf;
   logic              mac_reset;
   logic              mac_enable;
   logic [DATA_W-1:0] mac_x;
   logic [DATA_W-1:0] mac_w;
   logic [ACC_W-1:0]  mac_acc;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   xm [DEPTH];
   int   wm [DEPTH];

   always #5 clk = ~clk;

   mac_operand_sequencer #(
      .DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .len(len),
      .busy(busy), .done(done), .result(result), .ovf(ovf),
      .mac_reset(mac_reset), .mac_enable(mac_enable),
      .mac_x(mac_x), .mac_w(mac_w), .mac_acc(mac_acc)
   );

   // Behavioural mac_unit: clear on mac_reset, else accumulate modulo 2^ACC_W.
   always @(posedge clk) begin
      if (reset || mac_reset) mac_acc <= '0;
      else if (mac_enable)    mac_acc <= mac_acc + ({8'b0, mac_x} * {8'b0, mac_w});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Queue the expected outcome of a run of n requested pairs.
   task automatic push_exp(input int n);
      exp_t e;
      int   eff;
      int   sum;
      eff = (n > DEPTH) ? DEPTH : n;
      sum = 0;
      for (int i = 0; i < eff; i++) sum += xm[i] * wm[i];
      e.result = sum[ACC_W-1:0];
`ifdef MAC_SEQ_OVF_DETECT_EN
      e.ovf = (sum >= 65536);
`else
      e.ovf = 1'b0;
`endif
      e.lat = eff + 3;
      e.nen = eff;
      sb.push_back(e);
   endtask

   task automatic write_op(input bit sel, input int addr, input int data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = ADDR_W'(addr); wr_data = DATA_W'(data);
      if (sel) wm[addr] = data; else xm[addr] = data;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic load_basic();
      write_op(0, 0, 2); write_op(0, 1, 4); write_op(0, 2, 6);
      write_op(1, 0, 3); write_op(1, 1, 5); write_op(1, 2, 7);
   endtask

   // One run: start with len n, watch until done, compare against the scoreboard.
   // With disturb set, start and a write to x[0] are pulsed in the middle of the run.
   task automatic do_run(input int n, input bit disturb, input string tag);
      int   k, nen;
      bit   got, busy_bad;
      exp_t e;
      push_exp(n);
      start = 1'b1; len = (ADDR_W+1)'(n);
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      k = 0; nen = 0; got = 1'b0; busy_bad = 1'b0;
      while (!got && k < 100) begin
         @(negedge clk); k++;
         if (done === 1'b1) begin
            got = 1'b1;
         end else begin
            if (mac_enable === 1'b1) nen++;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (disturb && k == 2) begin
               start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd99;
            end
            if (disturb && k == 3) begin
               start = 1'b0; wr_en = 1'b0;
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s done_timeout: no done within 100 cycles", tag);
         if (sb.size() > 0) sb.delete(0);
      end else begin
         e = sb.pop_front();
         checks++;
         if (result !== e.result) begin
            errors++; $display("FAIL %s result: got %0d expected %0d", tag, result, e.result);
         end
         checks++;
         if (ovf !== e.ovf) begin
            errors++; $display("FAIL %s ovf: got %b expected %b", tag, ovf, e.ovf);
         end
         checks++;
         if (k != e.lat) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", tag, k, e.lat);
         end
         checks++;
         if (nen != e.nen) begin
            errors++; $display("FAIL %s enable_cycles: got %0d expected %0d", tag, nen, e.nen);
         end
         checks++;
         if (busy !== 1'b0 || busy_bad) begin
            errors++; $display("FAIL %s busy: at_done=%b gap_seen=%b expected 0/0", tag, busy, busy_bad);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; len = '0;
      for (int i = 0; i < DEPTH; i++) begin xm[i] = 0; wm[i] = 0; end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, ovf, mac_reset, mac_enable} !== 5'b0 || result !== '0 ||
          mac_x !== '0 || mac_w !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b ovf=%b mrst=%b men=%b result=%0d x=%0d w=%0d expected all 0",
                  busy, done, ovf, mac_reset, mac_enable, result, mac_x, mac_w);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      load_basic();
      do_run(3, 1'b0, "basic");
   endtask

   task automatic test_len_zero();
      do_run(0, 1'b0, "len_zero");
   endtask

   task automatic test_busy_protect();
      bit idle_bad;
      do_run(3, 1'b1, "busy_protect");
      idle_bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || mac_enable !== 1'b0) idle_bad = 1'b1;
      end
      checks++;
      if (idle_bad) begin
         errors++; $display("FAIL busy_protect second_run: activity seen=%b expected 0", idle_bad);
      end
      @(posedge clk); #1;
      do_run(3, 1'b0, "busy_protect_rerun");
   endtask

   task automatic test_clamp();
      for (int i = 0; i < DEPTH; i++) begin
         write_op(0, i, 1);
         write_op(1, i, 1);
      end
      do_run(20, 1'b0, "clamp");
   endtask

   task automatic test_overflow();
      write_op(0, 0, 255); write_op(0, 1, 255); write_op(1, 0, 255);
      // w[1] is written on the same edge that samples start.
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd1; wr_data = 8'd255; wm[1] = 255;
      do_run(2, 1'b0, "overflow");
   endtask

   task automatic test_back_to_back();
      int   k, nd;
      int   d [2];
      exp_t e;
      push_exp(2); push_exp(2);
      start = 1'b1; len = 5'd2;
      @(posedge clk); #1;
      k = 0; nd = 0; d[0] = -1; d[1] = -1;
      while (nd < 2 && k < 60) begin
         @(negedge clk); k++;
         if (done === 1'b1) begin
            d[nd] = k;
            e = sb.pop_front();
            checks++;
            if (result !== e.result) begin
               errors++; $display("FAIL b2b result%0d: got %0d expected %0d", nd, result, e.result);
            end
            nd++;
            if (nd == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      checks++;
      if (d[0] != 5 || d[1] != 11) begin
         errors++; $display("FAIL b2b done_cycles: got %0d,%0d expected 5,11", d[0], d[1]);
      end
      while (sb.size() > 0) sb.delete(0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_stream();
      bit late_bad;
      load_basic();
      start = 1'b1; len = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);   // cycle 3 is the second STREAM cycle
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mac_enable !== 1'b0 || result !== '0 || done !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b men=%b result=%0d done=%b ovf=%b expected 0",
                  busy, mac_enable, result, done, ovf);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin xm[i] = 0; wm[i] = 0; end
      late_bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) late_bad = 1'b1;
      end
      checks++;
      if (late_bad) begin
         errors++; $display("FAIL reset_mid late_done: activity seen=%b expected 0", late_bad);
      end
      @(posedge clk); #1;
      do_run(3, 1'b0, "reset_cleared_bufs");
      load_basic();
      do_run(3, 1'b0, "reset_fresh_run");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_busy_protect();
      test_clamp();
      test_overflow();
      test_back_to_back();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
